// File: rtl/rf_pkg.sv
// Shared constants for the two-read / one-write register file.
// Holds the default geometry and the bytes-per-word helper.
package rf_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int BYTES_DEF      = DATA_WIDTH_DEF / 8;

    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the register file.
// The master drives writes and read requests; the slave returns registered read data.
interface reg_file_2r1w_if
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                    we;
    logic [ADDR_WIDTH-1:0]   wAddr;
    logic [DATA_WIDTH-1:0]   wData;
    logic [DATA_WIDTH/8-1:0] wBe;
    logic                    reA;
    logic                    reB;
    logic [ADDR_WIDTH-1:0]   rAddrA;
    logic [ADDR_WIDTH-1:0]   rAddrB;
    logic [DATA_WIDTH-1:0]   rDataA;
    logic [DATA_WIDTH-1:0]   rDataB;
    logic                    rValidA;
    logic                    rValidB;

    modport master (
        output we, wAddr, wData, wBe, reA, reB, rAddrA, rAddrB,
        input  rDataA, rDataB, rValidA, rValidB
    );

    modport slave (
        input  we, wAddr, wData, wBe, reA, reB, rAddrA, rAddrB,
        output rDataA, rDataB, rValidA, rValidB
    );
endinterface

// File: rtl/rf_word.sv
// One register-file entry: byte-enabled data register plus a written-since-reset flag.
module rf_word
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    valid
);
    localparam int NB = byte_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    // valid is set by any write, even one with no byte lanes enabled
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (we) begin
            valid_d = 1'b1;
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) data_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one byte-enabled write port and two registered read ports,
// optional write-to-read forwarding and optional hardwired-zero entry 0.
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wAddr,
    input  logic [DATA_WIDTH-1:0]   wData,
    input  logic [DATA_WIDTH/8-1:0] wBe,
    input  logic                    reA,
    input  logic                    reB,
    input  logic [ADDR_WIDTH-1:0]   rAddrA,
    input  logic [ADDR_WIDTH-1:0]   rAddrB,
    output logic [DATA_WIDTH-1:0]   rDataA,
    output logic [DATA_WIDTH-1:0]   rDataB,
    output logic                    rValidA,
    output logic                    rValidB
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = byte_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] ent_data  [DEPTH];
    logic                  ent_valid [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic ent_we;
            // a hardwired-zero entry never sees a write; reads of it are forced below
            assign ent_we = we && (wAddr == ADDR_WIDTH'(gi)) && !(ZERO_REG && gi == 0);

            rf_word #(.DATA_WIDTH(DATA_WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .we    (ent_we),
                .wdata (wData),
                .wbe   (wBe),
                .data  (ent_data[gi]),
                .valid (ent_valid[gi])
            );
        end
    endgenerate

    logic                  port_re   [2];
    logic [ADDR_WIDTH-1:0] port_addr [2];

    assign port_re[0]   = reA;
    assign port_re[1]   = reB;
    assign port_addr[0] = rAddrA;
    assign port_addr[1] = rAddrB;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;
            logic [DATA_WIDTH-1:0] sel_data;
            logic                  sel_valid;
            logic                  is_zero;
            logic                  fwd_hit;

            always_comb begin
                is_zero   = ZERO_REG && (port_addr[gi] == '0);
                fwd_hit   = BYPASS && we && (wAddr == port_addr[gi]) && !is_zero;
                sel_data  = ent_data[port_addr[gi]];
                sel_valid = ent_valid[port_addr[gi]];
                if (fwd_hit) begin
                    sel_valid = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        if (wBe[i]) sel_data[8*i +: 8] = wData[8*i +: 8];
                    end
                end
                if (is_zero) begin
                    sel_data  = '0;
                    sel_valid = 1'b1;
                end
                rdata_d  = port_re[gi] ? sel_data  : rdata_q;
                rvalid_d = port_re[gi] ? sel_valid : rvalid_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end
        end
    endgenerate

    assign rDataA  = g_port[0].rdata_q;
    assign rValidA = g_port[0].rvalid_q;
    assign rDataB  = g_port[1].rdata_q;
    assign rValidB = g_port[1].rvalid_q;
endmodule
